// File: rtl/router_sync_param_if.sv
// rtl/router_sync_param_if.sv - router/FIFO synchroniser signal bundle with master and slave views
interface router_sync_param_if #(
    parameter int NUM_CH = 3
);
    localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

    logic [ADDR_W-1:0] data_in;
    logic              detect_add;
    logic              write_enb_reg;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] status_clr;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic              addr_err;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic [NUM_CH-1:0] timeout_sts;

    // FSM / register block / FIFO side that drives the synchroniser
    modport master (
        output data_in, detect_add, write_enb_reg, full, empty, read_enb, status_clr,
        input  write_enb, fifo_full, addr_err, vld_out, soft_reset, timeout_sts
    );

    // the synchroniser itself
    modport slave (
        input  data_in, detect_add, write_enb_reg, full, empty, read_enb, status_clr,
        output write_enb, fifo_full, addr_err, vld_out, soft_reset, timeout_sts
    );
endinterface

// File: rtl/router_sync_param.sv
// rtl/router_sync_param.sv - address latch/decode, valid flags and per-FIFO idle timeout soft reset
module router_sync_param #(
    parameter int NUM_CH    = 3,
    parameter int TIMEOUT   = 30,
    parameter int TIMEOUT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    router_sync_param_if.slave bus
);
    localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    // one extra bit so NUM_CH itself is representable for the range check
    localparam logic [ADDR_W:0]      NUM_CH_W = (ADDR_W + 1)'(NUM_CH);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = TIMEOUT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 addr_err_q, addr_err_d;
    logic [NUM_CH-1:0]    we_c;
    logic                 ff_c;
    logic [NUM_CH-1:0]    idle;
    logic [TIMEOUT_W-1:0] cnt_q [NUM_CH];
    logic [TIMEOUT_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0]    soft_q, soft_d;
    logic [NUM_CH-1:0]    sts_q, sts_d;

    // header strobe captures the destination and flags out-of-range channels
    always_comb begin
        addr_d     = addr_q;
        addr_err_d = addr_err_q;
        if (bus.detect_add) begin
            addr_d     = bus.data_in;
            addr_err_d = ({1'b0, bus.data_in} >= NUM_CH_W);
        end
    end

    // address and error flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // one-hot write enable and full mux; an invalid address drops the data
    always_comb begin
        we_c = '0;
        ff_c = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!addr_err_q && (addr_q == ADDR_W'(i))) begin
                we_c[i] = bus.write_enb_reg;
                ff_c    = bus.full[i];
            end
        end
    end

    assign idle = ~bus.empty & ~bus.read_enb;

    // per-channel idle counters; the pulse and the counter clear happen on the same edge
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = '0;
            soft_d[i] = 1'b0;
            if (idle[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    soft_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + TIMEOUT_W'(1);
                end
            end
            // a new timeout outranks a clear arriving in the same cycle
            sts_d[i] = soft_d[i] | (sts_q[i] & ~bus.status_clr[i]);
        end
    end

    // counter, pulse and sticky status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            soft_q <= '0;
            sts_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            soft_q <= soft_d;
            sts_q  <= sts_d;
        end
    end

    assign bus.write_enb   = we_c;
    assign bus.fifo_full   = ff_c;
    assign bus.addr_err    = addr_err_q;
    assign bus.vld_out     = ~bus.empty;
    assign bus.soft_reset  = soft_q;
    assign bus.timeout_sts = sts_q;
endmodule

// File: tb/tb_router_sync_param.sv
// tb/tb_router_sync_param.sv - self-checking bench for two router_sync_param configurations
module tb_router_sync_param;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    // index 0: NUM_CH=3 TIMEOUT=30; index 1: NUM_CH=8 TIMEOUT=4 TIMEOUT_W=3
    logic        reset_v [2];
    logic [15:0] full_v  [2];
    logic [15:0] empty_v [2];
    logic [15:0] rd_v    [2];
    logic [15:0] clr_v   [2];
    logic [3:0]  din_v   [2];
    logic        det_v   [2];
    logic        wer_v   [2];

    logic [15:0] we_w  [2];
    logic [15:0] vld_w [2];
    logic [15:0] sr_w  [2];
    logic [15:0] sts_w [2];
    logic        ff_w  [2];
    logic        err_w [2];
    logic        reset_a, reset_b;

    router_sync_param_if #(.NUM_CH(3)) ifa ();
    router_sync_param_if #(.NUM_CH(8)) ifb ();

    router_sync_param #(.NUM_CH(3), .TIMEOUT(30), .TIMEOUT_W(5)) dut_a (
        .clock(clock), .reset(reset_a), .bus(ifa.slave));
    router_sync_param #(.NUM_CH(8), .TIMEOUT(4), .TIMEOUT_W(3)) dut_b (
        .clock(clock), .reset(reset_b), .bus(ifb.slave));

    assign reset_a           = reset_v[0];
    assign reset_b           = reset_v[1];
    assign ifa.data_in       = din_v[0][1:0];
    assign ifa.detect_add    = det_v[0];
    assign ifa.write_enb_reg = wer_v[0];
    assign ifa.full          = full_v[0][2:0];
    assign ifa.empty         = empty_v[0][2:0];
    assign ifa.read_enb      = rd_v[0][2:0];
    assign ifa.status_clr    = clr_v[0][2:0];
    assign ifb.data_in       = din_v[1][2:0];
    assign ifb.detect_add    = det_v[1];
    assign ifb.write_enb_reg = wer_v[1];
    assign ifb.full          = full_v[1][7:0];
    assign ifb.empty         = empty_v[1][7:0];
    assign ifb.read_enb      = rd_v[1][7:0];
    assign ifb.status_clr    = clr_v[1][7:0];

    assign we_w[0]  = 16'(ifa.write_enb);
    assign vld_w[0] = 16'(ifa.vld_out);
    assign sr_w[0]  = 16'(ifa.soft_reset);
    assign sts_w[0] = 16'(ifa.timeout_sts);
    assign ff_w[0]  = ifa.fifo_full;
    assign err_w[0] = ifa.addr_err;
    assign we_w[1]  = 16'(ifb.write_enb);
    assign vld_w[1] = 16'(ifb.vld_out);
    assign sr_w[1]  = 16'(ifb.soft_reset);
    assign sts_w[1] = 16'(ifb.timeout_sts);
    assign ff_w[1]  = ifb.fifo_full;
    assign err_w[1] = ifb.addr_err;

    int checks = 0;
    int errors = 0;
    int nch [2] = '{3, 8};
    int tmo [2] = '{30, 4};

    // reference model: latched destination plus length of the current unread-valid run
    int          m_addr  [2];
    bit          m_err   [2];
    int          m_run   [2][16];
    bit [15:0]   m_pulse [2];
    bit [15:0]   m_sts   [2];
    logic [15:0] last_sr [2];

    task automatic cmp(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    task automatic model_clear(input int d);
        m_addr[d]  = 0;
        m_err[d]   = 1'b0;
        m_pulse[d] = '0;
        m_sts[d]   = '0;
        for (int c = 0; c < 16; c++) m_run[d][c] = 0;
    endtask

    task automatic model_update(input int d);
        if (det_v[d]) begin
            m_addr[d] = int'(din_v[d]);
            m_err[d]  = (int'(din_v[d]) >= nch[d]);
        end
        for (int c = 0; c < nch[d]; c++) begin
            m_pulse[d][c] = 1'b0;
            if (!empty_v[d][c] && !rd_v[d][c]) begin
                m_run[d][c]++;
                if (m_run[d][c] == tmo[d]) begin
                    m_pulse[d][c] = 1'b1;
                    m_run[d][c]   = 0;
                end
            end else begin
                m_run[d][c] = 0;
            end
            if (m_pulse[d][c]) m_sts[d][c] = 1'b1;
            else if (clr_v[d][c]) m_sts[d][c] = 1'b0;
        end
    endtask

    task automatic check_dut(input int d);
        logic [15:0] mask, exp_we;
        logic        exp_ff;
        mask   = (16'd1 << nch[d]) - 16'd1;
        exp_we = '0;
        exp_ff = 1'b0;
        if (!m_err[d]) begin
            if (wer_v[d]) exp_we = 16'd1 << m_addr[d];
            exp_ff = full_v[d][m_addr[d]];
        end
        cmp("write_enb",   d, we_w[d],         exp_we);
        cmp("fifo_full",   d, 16'(ff_w[d]),    16'(exp_ff));
        cmp("addr_err",    d, 16'(err_w[d]),   16'(m_err[d]));
        cmp("vld_out",     d, vld_w[d],        ~empty_v[d] & mask);
        cmp("soft_reset",  d, sr_w[d],         m_pulse[d]);
        cmp("timeout_sts", d, sts_w[d],        m_sts[d]);
    endtask

    // one clock: settle, compare both DUTs, advance the model, cross the edge
    task automatic cycle();
        #1;
        check_dut(0);
        check_dut(1);
        last_sr[0] = sr_w[0];
        last_sr[1] = sr_w[1];
        for (int d = 0; d < 2; d++) begin
            if (reset_v[d]) model_clear(d);
            else model_update(d);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle(input int d);
        full_v[d]  = '0;
        empty_v[d] = 16'hFFFF;
        rd_v[d]    = '0;
        clr_v[d]   = '0;
        din_v[d]   = '0;
        det_v[d]   = 1'b0;
        wer_v[d]   = 1'b0;
    endtask

    task automatic hold_reset(input int d);
        reset_v[d] = 1'b1;
        model_clear(d);
        #1;
        check_dut(d);
        cycle();
        reset_v[d] = 1'b0;
    endtask

    typedef struct {
        logic       det;
        logic [1:0] din;
        logic       wer;
        logic [2:0] full;
        logic [2:0] we;
        logic       ff;
        logic       err;
    } vec_t;

    vec_t tbl [11];
    int   pulses [$];
    int   simul;
    int   ones;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 3'b011, 3'b100, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'd3, 1'b1, 3'b111, 3'b010, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0};

        for (int d = 0; d < 2; d++) begin
            set_idle(d);
            reset_v[d] = 1'b0;
            model_clear(d);
        end
        #2;
        hold_reset(0);
        hold_reset(1);

        // decode and invalid-address vectors on the 3-channel instance
        for (int i = 0; i < 11; i++) begin
            det_v[0]  = tbl[i].det;
            din_v[0]  = {2'b00, tbl[i].din};
            wer_v[0]  = tbl[i].wer;
            full_v[0] = {13'd0, tbl[i].full};
            #1;
            cmp("tbl_write_enb", 0, we_w[0],         16'(tbl[i].we));
            cmp("tbl_fifo_full", 0, 16'(ff_w[0]),    16'(tbl[i].ff));
            cmp("tbl_addr_err",  0, 16'(err_w[0]),   16'(tbl[i].err));
            cycle();
        end
        set_idle(0);

        // steady idling: pulses at cycles 30 and 60, status cleared mid-way
        hold_reset(0);
        pulses.delete();
        for (int k = 0; k < 62; k++) begin
            empty_v[0] = 16'hFFFE;
            clr_v[0]   = (k == 45) ? 16'h0001 : 16'h0000;
            cycle();
            if (last_sr[0][0]) pulses.push_back(k);
        end
        cmp("idle_pulse_count", 0, 16'(pulses.size()), 16'd2);
        if (pulses.size() == 2) begin
            cmp("idle_pulse_first",  0, 16'(pulses[0]), 16'd30);
            cmp("idle_pulse_second", 0, 16'(pulses[1]), 16'd60);
        end
        set_idle(0);

        // one read in cycle 29 restarts the window
        hold_reset(0);
        pulses.delete();
        for (int k = 0; k < 71; k++) begin
            empty_v[0] = 16'hFFFE;
            rd_v[0]    = (k == 29) ? 16'h0001 : 16'h0000;
            cycle();
            if (last_sr[0][0]) pulses.push_back(k);
        end
        cmp("restart_pulse_count", 0, 16'(pulses.size()), 16'd1);
        if (pulses.size() == 1) cmp("restart_pulse_cycle", 0, 16'(pulses[0]), 16'd60);
        set_idle(0);

        // asynchronous reset at idle cycle 20, then a full window from release
        hold_reset(0);
        pulses.delete();
        for (int k = 0; k < 20; k++) begin
            empty_v[0] = 16'hFFFE;
            cycle();
            if (last_sr[0][0]) pulses.push_back(k);
        end
        #1;
        reset_v[0] = 1'b1;
        model_clear(0);
        #1;
        check_dut(0);
        cycle();
        reset_v[0] = 1'b0;
        for (int k = 0; k < 36; k++) begin
            empty_v[0] = 16'hFFFE;
            cycle();
            if (last_sr[0][0]) pulses.push_back(k);
        end
        cmp("reset_pulse_count", 0, 16'(pulses.size()), 16'd1);
        if (pulses.size() == 1) cmp("reset_pulse_cycle", 0, 16'(pulses[0]), 16'd30);
        set_idle(0);

        // randomized traffic on the 8-channel, TIMEOUT=4 instance
        simul = 0;
        for (int k = 0; k < 400; k++) begin
            empty_v[1] = 16'($urandom() & $urandom() & $urandom()) & 16'h00FF;
            rd_v[1]    = 16'($urandom() & $urandom() & $urandom()) & 16'h00FF;
            clr_v[1]   = 16'($urandom() & $urandom()) & 16'h00FF;
            full_v[1]  = 16'($urandom()) & 16'h00FF;
            det_v[1]   = ($urandom_range(0, 3) == 0);
            din_v[1]   = 4'($urandom_range(0, 7));
            wer_v[1]   = 1'($urandom());
            if ($urandom_range(0, 99) == 0) begin
                #1;
                reset_v[1] = 1'b1;
                model_clear(1);
                #1;
                check_dut(1);
                cycle();
                reset_v[1] = 1'b0;
            end else begin
                cycle();
                ones = $countones(last_sr[1]);
                if (ones >= 2) simul++;
            end
        end
        checks++;
        if (simul == 0) begin
            errors++;
            $display("FAIL simultaneous_pulses dut1: got %0d cycles expected at least 1", simul);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
